// File: rtl/deadlock_block_detector_pkg.sv
// Shared types and helpers for the kernel deadlock monitors.
// The stall rule lives here so every monitor flavour evaluates it identically.
package deadlock_mon_pkg;

    localparam int DEFAULT_THRESH = 16;
    localparam int DEFAULT_CNT_W  = 16;
    localparam int MAX_CH         = 32;

    typedef enum logic [1:0] {
        RUN     = 2'd0,
        COUNT   = 2'd1,
        BLOCKED = 2'd2
    } dl_state_t;

    // Unused channel slots must be padded as idle, inst slots as not blocked.
    function automatic logic stall_now_f(
        input logic [MAX_CH-1:0] axis_blk,
        input logic [MAX_CH-1:0] inst_idle,
        input logic [MAX_CH-1:0] inst_blk
    );
        logic [MAX_CH-1:0] active;
        active = ~inst_idle;
        return (|(active & axis_blk) | |inst_blk) & ~|(active & ~axis_blk);
    endfunction

endpackage

// File: rtl/deadlock_block_detector_if.sv
// Flag bundle between the kernel deadlock monitor top (master) and the detector (slave).
interface deadlock_block_detector_if
    import deadlock_mon_pkg::*;
#(
    parameter int N_AXIS = 4,
    parameter int N_INST = 1,
    parameter int CNT_W  = DEFAULT_CNT_W
);
    logic [N_AXIS-1:0] axis_block_sigs;
    logic [N_AXIS-1:0] inst_idle_sigs;
    logic [N_INST-1:0] inst_block_sigs;
    logic              block;
    logic              block_event;
    logic [N_AXIS-1:0] block_mask;
    logic [CNT_W-1:0]  stall_cycles;

    modport master (
        output axis_block_sigs, inst_idle_sigs, inst_block_sigs,
        input  block, block_event, block_mask, stall_cycles
    );

    modport slave (
        input  axis_block_sigs, inst_idle_sigs, inst_block_sigs,
        output block, block_event, block_mask, stall_cycles
    );
endinterface

// File: rtl/deadlock_block_detector_sat_counter.sv
// Stall-cycle counter: clear has priority, increment sticks at all-ones.
module deadlock_sat_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             clr,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);
    always_ff @(posedge clock) begin
        if (reset || clr) begin
            count <= '0;
        end else if (inc && (count != {CNT_W{1'b1}})) begin
            count <= count + CNT_W'(1);
        end
    end
endmodule

// File: rtl/deadlock_block_detector.sv
// Persistence-filtered kernel deadlock detector with stalled-channel snapshot.
//   state   | meaning
//   RUN     | forward progress seen last sample, counter at zero
//   COUNT   | consecutive stalled samples accumulating, below threshold
//   BLOCKED | deadlock confirmed, counter keeps running until progress
module deadlock_block_detector
    import deadlock_mon_pkg::*;
#(
    parameter int N_AXIS = 4,
    parameter int N_INST = 1,
    parameter int THRESH = DEFAULT_THRESH,
    parameter int CNT_W  = DEFAULT_CNT_W
) (
    input logic                    clock,
    input logic                    reset,
    deadlock_block_detector_if.slave mon
);
    dl_state_t         state, state_nxt;
    logic [MAX_CH-1:0] blk_w, idle_w, iblk_w;
    logic [N_AXIS-1:0] stalled;
    logic [N_AXIS-1:0] mask_q;
    logic [CNT_W-1:0]  count;
    logic              stall_now;
    logic              cnt_clr, cnt_inc, fire, event_q;

    always_comb begin
        blk_w  = '0;
        idle_w = '1;
        iblk_w = '0;
        blk_w[N_AXIS-1:0]  = mon.axis_block_sigs;
        idle_w[N_AXIS-1:0] = mon.inst_idle_sigs;
        iblk_w[N_INST-1:0] = mon.inst_block_sigs;
    end

    assign stall_now = stall_now_f(blk_w, idle_w, iblk_w);
    assign stalled   = mon.axis_block_sigs & ~mon.inst_idle_sigs;

    always_comb begin
        state_nxt = state;
        cnt_clr   = 1'b0;
        cnt_inc   = 1'b0;
        fire      = 1'b0;
        case (state)
            RUN: begin
                if (stall_now) begin
                    cnt_inc = 1'b1;
                    if (THRESH == 1) begin
                        state_nxt = BLOCKED;
                        fire      = 1'b1;
                    end else begin
                        state_nxt = COUNT;
                    end
                end else begin
                    cnt_clr = 1'b1;
                end
            end
            COUNT: begin
                if (!stall_now) begin
                    state_nxt = RUN;
                    cnt_clr   = 1'b1;
                end else begin
                    cnt_inc = 1'b1;
                    // count+1 reaches THRESH on this sample
                    if (count == CNT_W'(THRESH - 1)) begin
                        state_nxt = BLOCKED;
                        fire      = 1'b1;
                    end
                end
            end
            BLOCKED: begin
                if (!stall_now) begin
                    state_nxt = RUN;
                    cnt_clr   = 1'b1;
                end else begin
                    cnt_inc = 1'b1;
                end
            end
            default: begin
                state_nxt = RUN;
                cnt_clr   = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state   <= RUN;
            event_q <= 1'b0;
            mask_q  <= '0;
        end else begin
            state   <= state_nxt;
            event_q <= fire;
            if (fire) begin
                mask_q <= stalled;
            end
        end
    end

    deadlock_sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
        .clock (clock),
        .reset (reset),
        .clr   (cnt_clr),
        .inc   (cnt_inc),
        .count (count)
    );

    assign mon.block        = (state == BLOCKED);
    assign mon.block_event  = event_q;
    assign mon.block_mask   = mask_q;
    assign mon.stall_cycles = count;
endmodule

// File: tb/tb_deadlock_block_detector.sv
// Randomized bench for deadlock_block_detector: two configurations checked against a run-length model.
module tb_deadlock_block_detector;

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    deadlock_block_detector_if #(.N_AXIS(4), .N_INST(1), .CNT_W(16)) bus_a ();
    deadlock_block_detector_if #(.N_AXIS(4), .N_INST(1), .CNT_W(4))  bus_b ();

    deadlock_block_detector #(.N_AXIS(4), .N_INST(1), .THRESH(16), .CNT_W(16)) dut_a (
        .clock (clock),
        .reset (reset),
        .mon   (bus_a.slave)
    );

    deadlock_block_detector #(.N_AXIS(4), .N_INST(1), .THRESH(8), .CNT_W(4)) dut_b (
        .clock (clock),
        .reset (reset),
        .mon   (bus_b.slave)
    );

    int total = 0;
    int bad   = 0;

    // reference: length of the current run of stalled samples, unbounded
    int         run_len = 0;
    int         thr [2] = '{16, 8};
    int         sat [2] = '{65535, 15};
    logic [3:0] exp_mask [2] = '{4'h0, 4'h0};
    logic [3:0] cur_blk  = 4'h0;
    logic [3:0] cur_idle = 4'h0;
    logic       cur_iblk = 1'b0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic drive(input logic [3:0] blk, input logic [3:0] idle, input logic iblk, input logic rst);
        cur_blk  = blk;
        cur_idle = idle;
        cur_iblk = iblk;
        reset    = rst;
        bus_a.axis_block_sigs    = blk;
        bus_a.inst_idle_sigs     = idle;
        bus_a.inst_block_sigs[0] = iblk;
        bus_b.axis_block_sigs    = blk;
        bus_b.inst_idle_sigs     = idle;
        bus_b.inst_block_sigs[0] = iblk;
    endtask

    task automatic model_update();
        logic [3:0] stl;
        bit         progress;
        bit         sn;
        stl      = 4'h0;
        progress = 0;
        for (int i = 0; i < 4; i++) begin
            if (!cur_idle[i] && cur_blk[i])  stl[i] = 1'b1;
            if (!cur_idle[i] && !cur_blk[i]) progress = 1;
        end
        sn = ((stl != 4'h0) || cur_iblk) && !progress;
        if (reset) begin
            run_len  = 0;
            exp_mask = '{4'h0, 4'h0};
        end else if (sn) begin
            run_len++;
            for (int d = 0; d < 2; d++)
                if (run_len == thr[d]) exp_mask[d] = stl;
        end else begin
            run_len = 0;
        end
    endtask

    task automatic compare_all();
        int ea, eb;
        ea = (run_len > sat[0]) ? sat[0] : run_len;
        eb = (run_len > sat[1]) ? sat[1] : run_len;
        check_val("a_block", 32'(bus_a.block),        32'(run_len >= thr[0]));
        check_val("a_event", 32'(bus_a.block_event),  32'(run_len == thr[0]));
        check_val("a_mask",  32'(bus_a.block_mask),   32'(exp_mask[0]));
        check_val("a_stall", 32'(bus_a.stall_cycles), 32'(ea));
        check_val("b_block", 32'(bus_b.block),        32'(run_len >= thr[1]));
        check_val("b_event", 32'(bus_b.block_event),  32'(run_len == thr[1]));
        check_val("b_mask",  32'(bus_b.block_mask),   32'(exp_mask[1]));
        check_val("b_stall", 32'(bus_b.stall_cycles), 32'(eb));
    endtask

    task automatic step(input logic [3:0] blk, input logic [3:0] idle, input logic iblk,
                        input logic rst, input int n);
        for (int c = 0; c < n; c++) begin
            drive(blk, idle, iblk, rst);
            @(posedge clock);
            model_update();
            @(negedge clock);
            compare_all();
        end
    endtask

    initial begin
        // reset with random inputs
        for (int c = 0; c < 3; c++)
            step(4'($urandom), 4'($urandom), 1'($urandom), 1'b1, 1);
        step(4'h0, 4'h0, 1'b0, 1'b0, 2);

        // detection at threshold
        step(4'hf, 4'h0, 1'b0, 1'b0, 16);
        check_val("det_block", 32'(bus_a.block), 32'd1);
        check_val("det_event", 32'(bus_a.block_event), 32'd1);
        check_val("det_mask",  32'(bus_a.block_mask), 32'hf);
        check_val("det_stall", 32'(bus_a.stall_cycles), 32'd16);
        step(4'h0, 4'h0, 1'b0, 1'b0, 1);
        check_val("rel_block", 32'(bus_a.block), 32'd0);

        // progress on the threshold sample aborts
        step(4'hf, 4'h0, 1'b0, 1'b0, 15);
        step(4'hd, 4'h0, 1'b0, 1'b0, 1);
        check_val("abort_block", 32'(bus_a.block), 32'd0);
        check_val("abort_stall", 32'(bus_a.stall_cycles), 32'd0);

        // idle masking
        step(4'h9, 4'h6, 1'b0, 1'b0, 16);
        check_val("idle_block", 32'(bus_a.block), 32'd1);
        check_val("idle_mask",  32'(bus_a.block_mask), 32'h9);
        step(4'h9, 4'h6, 1'b0, 1'b0, 4);
        step(4'h0, 4'h0, 1'b0, 1'b0, 1);
        step(4'h0, 4'hf, 1'b0, 1'b0, 20);
        check_val("allidle_block", 32'(bus_a.block), 32'd0);

        // saturation, release, mid-block reset
        step(4'hf, 4'h0, 1'b0, 1'b0, 30);
        check_val("sat_stall_b", 32'(bus_b.stall_cycles), 32'd15);
        check_val("sat_stall_a", 32'(bus_a.stall_cycles), 32'd30);
        step(4'h0, 4'h0, 1'b0, 1'b0, 1);
        check_val("sat_rel_b", 32'(bus_b.block), 32'd0);
        step(4'hf, 4'h0, 1'b0, 1'b0, 10);
        check_val("pre_rst_b", 32'(bus_b.block), 32'd1);
        step(4'hf, 4'h0, 1'b0, 1'b1, 1);
        check_val("rst_block_b", 32'(bus_b.block), 32'd0);
        check_val("rst_mask_b",  32'(bus_b.block_mask), 32'd0);
        check_val("rst_stall_b", 32'(bus_b.stall_cycles), 32'd0);

        // randomized traffic biased toward long stalls
        for (int c = 0; c < 3000; c++) begin
            int         mode;
            logic [3:0] idle, blk;
            logic       iblk;
            mode = int'($urandom_range(0, 199));
            idle = 4'($urandom_range(0, 15) & $urandom_range(0, 15));
            blk  = (mode < 180) ? 4'hf : 4'($urandom);
            iblk = ($urandom_range(0, 9) == 0);
            step(blk, idle, iblk, mode < 2, 1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/deadlock_block_detector.md
# deadlock_block_detector

Persistence-filtered deadlock detector that consumes the per-channel AXI-stream block flags and per-instance idle/block flags gathered by the kernel deadlock monitor top. It decides when the kernel has made no forward progress for a programmable number of consecutive cycles and raises a kernel-level block indication. It also captures a diagnostic snapshot: which channels were stalled at detection, and how long the stall has lasted.

## Interface
- N_AXIS, 4: number of monitored AXI-stream channels. Channel i pairs with inst_idle_sigs[i].
- N_INST, 1: number of sub-instance block flags.
- THRESH, 16: consecutive stalled cycles required before block asserts. Legal range is 1..2^CNT_W-1.
- CNT_W, 16: width of the stall-cycle counter.
- clock  in  1  single clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high.
- axis_block_sigs  in  N_AXIS  1 = channel i is waiting on its stream (TDATA_blk_n low).
- inst_idle_sigs  in  N_AXIS  1 = the owner of channel i is idle. An idle owner's channel is ignored.
- inst_block_sigs  in  N_INST  1 = the sub-instance reports an internal block.
- block  out  1  kernel deadlock is confirmed.
- block_event  out  1  one-cycle pulse on the 0->1 transition of block.
- block_mask  out  N_AXIS  stalled-channel snapshot latched at the block_event.
- stall_cycles  out  CNT_W  saturating count of consecutive stalled cycles.

## Operation
- Per channel: active[i] = ~inst_idle_sigs[i]; stalled[i] = active[i] & axis_block_sigs[i].
- Per-cycle stall condition: stall_now = (|stalled | |inst_block_sigs) & ~|(active & ~axis_block_sigs).
  - Every active channel must be blocked, and at least one must be stalled or a sub-instance blocked.
  - All channels idle with no inst block gives stall_now = 0.
- FSM states and transitions:
  - RUN: counter = 0. If stall_now, go to COUNT with counter = 1. If THRESH == 1, go straight to BLOCKED instead.
  - COUNT: if stall_now is low, return to RUN and clear the counter. Otherwise increment the counter. When the incremented value equals THRESH, go to BLOCKED, pulse block_event and latch block_mask = stalled for that cycle.
  - BLOCKED: block = 1. The counter keeps incrementing and saturates at 2^CNT_W-1. If stall_now is low, return to RUN and clear the counter; block_mask holds its last value.
- block_mask updates only on block_event and otherwise holds.
- Simultaneous events: the stall_now of a cycle is evaluated before any transition. A progress cycle that coincides with the THRESH-th stalled sample counts as non-stalled, so no detection occurs.
- Reset mid-operation forces RUN with all outputs cleared, regardless of state.

## Timing
- Reset values: block = 0, block_event = 0, block_mask = 0, stall_cycles = 0, FSM = RUN.
- All outputs are registered; there is no combinational input-to-output path.
- If stall_now is high on sample cycles k .. k+THRESH-1:
  - block and block_event are high in cycle k+THRESH, which is THRESH cycles of latency after the first stalled sample.
  - stall_cycles reads n in cycle k+n.
- The first non-stalled sample in cycle m drops block in cycle m+1 and zeroes stall_cycles in the same cycle.
- Re-entry after deassertion needs a fresh THRESH consecutive samples.
- block_event never asserts in two consecutive cycles.

## Structure
- Shared package deadlock_mon_pkg holds:
  - the FSM state enum (RUN, COUNT, BLOCKED);
  - the default THRESH and CNT_W constants;
  - a function computing stall_now from the three input vectors, reused by the other idx monitors.
- One sub-module, deadlock_sat_counter: a CNT_W-bit saturating counter with clear and increment.
- The FSM, mask latch and event pulse live in the top.

## Test plan
- Reset check: drive reset for 3 cycles with random inputs. Required: every output is 0 during and after reset.
- Detection at threshold:
  - Stimulus: THRESH=16, inst_idle_sigs=4'b0000, axis_block_sigs=4'b1111 held for 16 cycles.
  - Required: block and block_event rise in cycle 16 (counting from the first stalled sample); block_mask=4'b1111; stall_cycles=16.
- Progress aborts the count:
  - Stimulus: all channels blocked for 15 cycles, then axis_block_sigs=4'b1101 for 1 cycle (channel 1 active and progressing).
  - Required: block stays 0 and stall_cycles returns to 0 in the next cycle.
- Idle masking:
  - Stimulus: inst_idle_sigs=4'b0110, axis_block_sigs=4'b1001 for 20 cycles.
  - Required: block rises at cycle 16 with block_mask=4'b1001.
  - Second stimulus: all channels idle and no inst block. Required: block never asserts.
- Release, saturation and mid-block reset:
  - Stimulus: CNT_W=4, THRESH=8, stall held 30 cycles.
  - Required: stall_cycles saturates at 15; a progress cycle drops block the next cycle; reset asserted while BLOCKED clears all outputs one cycle later.
